tag_memory_set_assoc: RTL and testbench

Parametrised tag store for the set-associative cache: per set it holds WAYS entries of {valid, dirty, tag}, performs a single-cycle combinational lookup and allocates new lines by per-set round-robin (FIFO) replacement. It is the generalised successor of the fixed 4-way, 5-bit-tag tag memory. Its additions are:
- a configurable geometry;
- explicit valid bits;
- line invalidation;
- optional dirty tracking;
- a self-clearing init sweep after reset.

It sits between the cache controller FSM and the data-way arrays.

---
 rtl/tag_memory_pkg.sv | 13 +
 rtl/tag_memory_init_sweep.sv | 52 +++++
 rtl/tag_memory_set_assoc.sv | 137 +++++++++++++
 tb/tb_tag_memory_set_assoc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_memory_pkg.sv
// Shared geometry defaults and init-sweep state encoding for the set-associative tag memory.
package tag_memory_pkg;

   localparam int TAG_WIDTH_DEFAULT   = 5;
   localparam int INDEX_WIDTH_DEFAULT = 7;
   localparam int WAYS_DEFAULT        = 4;

   typedef enum logic {
      SWEEP = 1'b0,
      READY = 1'b1
   } sweep_state_e;

endpackage

// File: rtl/tag_memory_init_sweep.sv
// Post-reset sweep: walks every set once, asserting sweep_we so the top clears valid/dirty/pointer.
//
// state | meaning
// SWEEP | clearing set[cnt]; busy=1; requests ignored
// READY | all sets cleared; requests honoured
module tag_memory_init_sweep
   import tag_memory_pkg::*;
#(
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   busy,
   output logic [INDEX_WIDTH-1:0] sweep_index,
   output logic                   sweep_we
);

   localparam logic [INDEX_WIDTH-1:0] LAST_SET = '1;

   sweep_state_e           state_q, state_d;
   logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SWEEP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy     = 1'b0;
      sweep_we = 1'b0;
      case (state_q)
         SWEEP: begin
            busy     = 1'b1;
            sweep_we = 1'b1;
            cnt_d    = cnt_q + INDEX_WIDTH'(1);
            if (cnt_q == LAST_SET) state_d = READY;
         end
         READY: ;
         default: state_d = SWEEP;
      endcase
   end

   assign sweep_index = cnt_q;

endmodule

// File: rtl/tag_memory_set_assoc.sv
// Set-associative tag store with combinational lookup and per-set round-robin allocation.
// Dirty-bit storage is built only when TAG_MEMORY_DIRTY_EN is defined.
module tag_memory_set_assoc
   import tag_memory_pkg::*;
#(
   parameter int TAG_WIDTH   = TAG_WIDTH_DEFAULT,
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEFAULT,
   parameter int WAYS        = WAYS_DEFAULT,
   localparam int WAY_W      = $clog2(WAYS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TAG_WIDTH-1:0]   tag,
   input  logic [INDEX_WIDTH-1:0] index,
   input  logic                   rewrite_tag,
   input  logic                   mark_dirty,
   input  logic                   invalidate,
   output logic                   busy,
   output logic                   is_hit,
   output logic [WAY_W-1:0]       channel,
   output logic                   need_use_fifo,
   output logic [WAY_W-1:0]       fifo_channel,
   output logic [TAG_WIDTH-1:0]   fifo_tag_for_flush,
   output logic                   victim_dirty
);

   localparam int SETS = 2**INDEX_WIDTH;

   logic [WAYS-1:0]      valid_q [SETS];
   logic [WAYS-1:0]      valid_d [SETS];
   logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
   logic [TAG_WIDTH-1:0] tag_d   [SETS][WAYS];
   logic [WAY_W-1:0]     ptr_q   [SETS];
   logic [WAY_W-1:0]     ptr_d   [SETS];
`ifdef TAG_MEMORY_DIRTY_EN
   logic [WAYS-1:0]      dirty_q [SETS];
   logic [WAYS-1:0]      dirty_d [SETS];
`else
   logic                 unused_mark_dirty;
   assign unused_mark_dirty = mark_dirty;
`endif

   logic                   busy_w;
   logic                   sweep_we;
   logic [INDEX_WIDTH-1:0] sweep_index;
   logic [WAYS-1:0]        hit_vec;
   logic                   hit_any;
   logic [WAY_W-1:0]       hit_way;
   logic [WAY_W-1:0]       victim_way;
   logic                   req_ok;

   tag_memory_init_sweep #(
      .INDEX_WIDTH(INDEX_WIDTH)
   ) u_init_sweep (
      .clk        (clk),
      .reset      (reset),
      .busy       (busy_w),
      .sweep_index(sweep_index),
      .sweep_we   (sweep_we)
   );

   always_comb begin
      hit_vec = '0;
      for (int w = 0; w < WAYS; w++)
         hit_vec[w] = valid_q[index][w] && (tag_q[index][w] == tag);
   end

   // Descending scan so the lowest matching way wins.
   always_comb begin
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (hit_vec[w]) hit_way = WAY_W'(w);
   end

   assign hit_any    = |hit_vec;
   assign victim_way = ptr_q[index];
   assign req_ok     = !busy_w && !reset;

   assign busy               = busy_w;
   assign is_hit             = hit_any && !busy_w;
   assign channel            = busy_w ? '0 : hit_way;
   assign need_use_fifo      = !busy_w && !hit_any && valid_q[index][victim_way];
   assign fifo_channel       = busy_w ? '0 : victim_way;
   assign fifo_tag_for_flush = busy_w ? '0 : tag_q[index][victim_way];
`ifdef TAG_MEMORY_DIRTY_EN
   assign victim_dirty = !busy_w && valid_q[index][victim_way] && dirty_q[index][victim_way];
`else
   assign victim_dirty = 1'b0;
`endif

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      ptr_d   = ptr_q;
`ifdef TAG_MEMORY_DIRTY_EN
      dirty_d = dirty_q;
`endif
      if (sweep_we) begin
         valid_d[sweep_index] = '0;
         ptr_d[sweep_index]   = '0;
`ifdef TAG_MEMORY_DIRTY_EN
         dirty_d[sweep_index] = '0;
`endif
      end else if (req_ok) begin
         if (rewrite_tag && !hit_any) begin
            valid_d[index][victim_way] = 1'b1;
            tag_d[index][victim_way]   = tag;
            ptr_d[index]               = victim_way + WAY_W'(1);
`ifdef TAG_MEMORY_DIRTY_EN
            dirty_d[index][victim_way] = mark_dirty;
`endif
         end
         if (invalidate && hit_any) begin
            valid_d[index][hit_way] = 1'b0;
`ifdef TAG_MEMORY_DIRTY_EN
            dirty_d[index][hit_way] = 1'b0;
`endif
         end
`ifdef TAG_MEMORY_DIRTY_EN
         else if (mark_dirty && hit_any) begin
            dirty_d[index][hit_way] = 1'b1;
         end
`endif
      end
   end

   // Arrays carry no reset; the init sweep establishes valid/dirty/pointer state.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
`ifdef TAG_MEMORY_DIRTY_EN
      dirty_q <= dirty_d;
`endif
   end

endmodule

// File: tb/tb_tag_memory_set_assoc.sv
// Scoreboard bench for tag_memory_set_assoc: directed scenarios then random traffic against a set/way model.
module tb_tag_memory_set_assoc;

   localparam int TW   = 5;
   localparam int IW   = 7;
   localparam int WAYS = 4;
   localparam int WW   = 2;
   localparam int SETS = 128;
`ifdef TAG_MEMORY_DIRTY_EN
   localparam bit DIRTY_EN = 1'b1;
`else
   localparam bit DIRTY_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [TW-1:0] tag;
   logic [IW-1:0] index;
   logic          rewrite_tag, mark_dirty, invalidate;
   logic          busy, is_hit, need_use_fifo, victim_dirty;
   logic [WW-1:0] channel, fifo_channel;
   logic [TW-1:0] fifo_tag_for_flush;

   always #5 clk = ~clk;

   tag_memory_set_assoc dut (
      .clk               (clk),
      .reset             (reset),
      .tag               (tag),
      .index             (index),
      .rewrite_tag       (rewrite_tag),
      .mark_dirty        (mark_dirty),
      .invalidate        (invalidate),
      .busy              (busy),
      .is_hit            (is_hit),
      .channel           (channel),
      .need_use_fifo     (need_use_fifo),
      .fifo_channel      (fifo_channel),
      .fifo_tag_for_flush(fifo_tag_for_flush),
      .victim_dirty      (victim_dirty)
   );

   typedef struct {
      bit busy;
      bit hit;
      int ch;
      bit nuf;
      int fch;
      int ftag;
      bit ftag_chk;
      bit vd;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;
   bit   chk_en = 0;

   // Reference state: one record per (set, way), plus a replacement pointer per set.
   bit m_valid [SETS][WAYS];
   bit m_dirty [SETS][WAYS];
   bit m_known [SETS][WAYS];
   int m_tag   [SETS][WAYS];
   int m_ptr   [SETS];
   int sweep_left = SETS;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int m_lookup(input int t, input int i);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[i][w] && m_tag[i][w] == t) return w;
      return -1;
   endfunction

   function automatic exp_t predict(input int t, input int i);
      exp_t e;
      int   w, v;
      e = '{busy: 0, hit: 0, ch: 0, nuf: 0, fch: 0, ftag: 0, ftag_chk: 0, vd: 0};
      if (sweep_left > 0) begin
         e.busy     = 1;
         e.ftag_chk = 1;
         return e;
      end
      w          = m_lookup(t, i);
      v          = m_ptr[i];
      e.hit      = (w >= 0);
      e.ch       = (w >= 0) ? w : 0;
      e.nuf      = (w < 0) && m_valid[i][v];
      e.fch      = v;
      e.ftag     = m_tag[i][v];
      e.ftag_chk = m_known[i][v];
      e.vd       = DIRTY_EN && m_valid[i][v] && m_dirty[i][v];
      return e;
   endfunction

   task automatic model_edge(input bit rst, input int t, input int i,
                             input bit rw, input bit md, input bit inv);
      int w, v;
      if (rst) begin
         sweep_left = SETS;
         for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int k = 0; k < WAYS; k++) begin
               m_valid[s][k] = 0;
               m_dirty[s][k] = 0;
            end
         end
      end else if (sweep_left > 0) begin
         sweep_left--;
      end else begin
         w = m_lookup(t, i);
         if (rw && w < 0) begin
            v             = m_ptr[i];
            m_valid[i][v] = 1;
            m_dirty[i][v] = DIRTY_EN && md;
            m_tag[i][v]   = t;
            m_known[i][v] = 1;
            m_ptr[i]      = (v + 1) % WAYS;
         end
         if (inv && w >= 0) begin
            m_valid[i][w] = 0;
            m_dirty[i][w] = 0;
         end else if (md && w >= 0 && DIRTY_EN) begin
            m_dirty[i][w] = 1;
         end
      end
   endtask

   // Called just after a rising edge: drive one cycle of inputs, queue expectation, advance the model.
   task automatic step(input int t, input int i, input bit rw, input bit md, input bit inv);
      tag         = TW'(t);
      index       = IW'(i);
      rewrite_tag = rw;
      mark_dirty  = md;
      invalidate  = inv;
      if (chk_en) exp_q.push_back(predict(t, i));
      @(posedge clk);
      model_edge(reset, t, i, rw, md, inv);
      chk_en = 1;
      #1;
   endtask

   task automatic count_busy();
      int n = 0;
      while (busy && n < 200) begin
         step(0, 1, 1, 0, 0);
         n++;
      end
      chk("busy_len", n, SETS);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("busy", int'(busy), int'(e.busy));
         chk("is_hit", int'(is_hit), int'(e.hit));
         chk("channel", int'(channel), e.ch);
         chk("need_use_fifo", int'(need_use_fifo), int'(e.nuf));
         chk("fifo_channel", int'(fifo_channel), e.fch);
         if (e.ftag_chk) chk("fifo_tag", int'(fifo_tag_for_flush), e.ftag);
         chk("victim_dirty", int'(victim_dirty), int'(e.vd));
      end
   end

   initial begin
      reset = 1'b1;
      for (int s = 0; s < SETS; s++)
         for (int k = 0; k < WAYS; k++) m_known[s][k] = 0;
      repeat (3) step(0, 0, 0, 0, 0);
      reset = 1'b0;

      // reset sweep; requests issued during busy must be ignored
      count_busy();
      step(0, 1, 0, 0, 0);

      // fill set 1
      for (int t = 0; t < 4; t++) begin
         step(t, 1, 1, 0, 0);
         step(t, 1, 0, 0, 0);
      end
      step(3, 1, 0, 0, 0);

      // eviction
      step(8, 1, 0, 0, 0);
      step(8, 1, 1, 0, 0);
      step(8, 1, 0, 0, 0);
      step(0, 5, 0, 0, 0);

      // dirty
      step(1, 1, 0, 1, 0);
      step(9, 1, 0, 0, 0);

      // invalidate, and invalidate winning over mark_dirty
      step(2, 1, 0, 0, 1);
      step(2, 1, 0, 0, 0);
      step(9, 1, 1, 0, 0);
      step(10, 1, 0, 0, 0);
      step(3, 1, 0, 1, 1);
      step(3, 1, 0, 0, 0);
      step(10, 1, 1, 1, 0);
      step(10, 1, 0, 0, 0);

      // reset mid-sweep
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      reset = 1'b0;
      repeat (50) step(0, 1, 1, 0, 0);
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      reset = 1'b0;
      count_busy();
      for (int t = 0; t < 12; t++) step(t, 1, 0, 0, 0);

      // random traffic over a few hot sets plus occasional far sets
      for (int n = 0; n < 3000; n++) begin
         int t, i;
         bit rw, md, inv;
         if (n == 1500) reset = 1'b1;
         if (n == 1501) reset = 1'b0;
         t   = $urandom_range(0, 9);
         i   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 2);
         rw  = ($urandom_range(0, 1) == 1);
         md  = ($urandom_range(0, 3) == 0);
         inv = ($urandom_range(0, 6) == 0);
         step(t, i, rw, md, inv);
      end
      step(0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
